// File: rtl/cdp_dp_mul_cvtout.sv
// CDP multiplier output converter: per-lane round-half-up shift and
// saturation to int8/int16, fp17 passthrough, sticky saturation counter.
module cdp_dp_mul_cvtout (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        mul_unit_vld,
  output logic        mul_unit_rdy,
  input  logic [49:0] mul_unit_pd,
  input  logic [1:0]  reg2dp_input_data_type,
  input  logic [4:0]  reg2dp_datout_shifter,
  input  logic        op_start,
  output logic        cvt_out_vld,
  input  logic        cvt_out_rdy,
  output logic [17:0] cvt_out_pd,
  output logic [31:0] dp2reg_out_saturation
);

  typedef enum logic [1:0] {
    MODE_INT8  = 2'd0,
    MODE_INT16 = 2'd1,
    MODE_FP16  = 2'd2
  } mode_e;

  function automatic logic [9:0] clamp8(input logic signed [33:0] v);
    if (v > 34'sd127)  return {1'b1, 9'h07F};
    if (v < -34'sd128) return {1'b1, 9'h180};
    return {1'b0, v[8:0]};
  endfunction

  function automatic logic [16:0] clamp16(input logic signed [33:0] v);
    if (v > 34'sd32767)  return {1'b1, 16'h7FFF};
    if (v < -34'sd32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  logic        s1_vld;
  logic        s2_vld;
  logic        s1_rdy;
  logic        s2_rdy;
  logic        s1_load;
  logic        s2_load;
  mode_e       s1_mode;
  logic [4:0]  s1_shift;
  logic [33:0] s1_msb;
  logic [33:0] s1_lsb;
  logic [31:0] sat_cnt;

  mode_e       in_mode;
  logic [33:0] rnd;
  logic [33:0] msb_in;
  logic [33:0] lsb_in;

  logic signed [33:0] msb_sh;
  logic signed [33:0] lsb_sh;
  logic [9:0]  c8m;
  logic [9:0]  c8l;
  logic [16:0] c16;
  logic [17:0] nxt_pd;
  logic [1:0]  nxt_inc;
  logic [32:0] sat_sum;

  assign s2_rdy       = ~s2_vld | cvt_out_rdy;
  assign s1_rdy       = ~s1_vld | s2_rdy;
  assign mul_unit_rdy = s1_rdy;
  assign s1_load      = mul_unit_vld & s1_rdy;
  assign s2_load      = s1_vld & s2_rdy;

  always_comb begin
    in_mode = MODE_INT16;
    rnd     = '0;
    msb_in  = {{9{mul_unit_pd[49]}}, mul_unit_pd[49:25]};
    lsb_in  = {mul_unit_pd[32], mul_unit_pd[32:0]};
    if (reg2dp_input_data_type == 2'd0) begin
      in_mode = MODE_INT8;
      lsb_in  = {{9{mul_unit_pd[24]}}, mul_unit_pd[24:0]};
    end else if (reg2dp_input_data_type == 2'd2) begin
      in_mode = MODE_FP16;
      lsb_in  = {17'b0, mul_unit_pd[16:0]};
    end
    // fp17 rides in the lsb lane untouched, so it gets no rounding term
    if (reg2dp_datout_shifter != 5'd0 && in_mode != MODE_FP16)
      rnd = 34'd1 << (reg2dp_datout_shifter - 5'd1);
  end

  assign msb_sh = $signed(s1_msb) >>> s1_shift;
  assign lsb_sh = $signed(s1_lsb) >>> s1_shift;
  assign c8m    = clamp8(msb_sh);
  assign c8l    = clamp8(lsb_sh);
  assign c16    = clamp16(lsb_sh);

  always_comb begin
    nxt_pd  = {{2{c16[15]}}, c16[15:0]};
    nxt_inc = {1'b0, c16[16]};
    case (s1_mode)
      MODE_INT8: begin
        nxt_pd  = {c8m[8:0], c8l[8:0]};
        nxt_inc = {1'b0, c8m[9]} + {1'b0, c8l[9]};
      end
      MODE_FP16: begin
        nxt_pd  = {s1_lsb[16], s1_lsb[16:0]};
        nxt_inc = 2'd0;
      end
      default: ;
    endcase
  end

  assign sat_sum = {1'b0, sat_cnt} + {31'b0, nxt_inc};

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld     <= 1'b0;
      s1_mode    <= MODE_INT8;
      s1_shift   <= '0;
      s1_msb     <= '0;
      s1_lsb     <= '0;
      s2_vld     <= 1'b0;
      cvt_out_pd <= '0;
      sat_cnt    <= '0;
    end else begin
      s1_vld <= s1_load | (s1_vld & ~s2_rdy);
      s2_vld <= s2_load | (s2_vld & ~cvt_out_rdy);
      if (s1_load) begin
        s1_mode  <= in_mode;
        s1_shift <= reg2dp_datout_shifter;
        s1_msb   <= msb_in + rnd;
        s1_lsb   <= lsb_in + rnd;
      end
      if (s2_load)
        cvt_out_pd <= nxt_pd;
      if (op_start)
        sat_cnt <= '0;
      else if (s2_load)
        sat_cnt <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
    end
  end

  assign cvt_out_vld           = s2_vld;
  assign dp2reg_out_saturation = sat_cnt;

endmodule

// File: tb/tb_cdp_dp_mul_cvtout.sv
// Randomized and directed bench for cdp_dp_mul_cvtout against an
// arithmetic reference model with a 2-slot in-flight queue.
module tb_cdp_dp_mul_cvtout;

  logic        clk;
  logic        rstn;
  logic        mul_unit_vld;
  logic        mul_unit_rdy;
  logic [49:0] mul_unit_pd;
  logic [1:0]  dtype;
  logic [4:0]  shift;
  logic        op_start;
  logic        cvt_out_vld;
  logic        cvt_out_rdy;
  logic [17:0] cvt_out_pd;
  logic [31:0] sat;

  cdp_dp_mul_cvtout dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .mul_unit_vld          (mul_unit_vld),
    .mul_unit_rdy          (mul_unit_rdy),
    .mul_unit_pd           (mul_unit_pd),
    .reg2dp_input_data_type(dtype),
    .reg2dp_datout_shifter (shift),
    .op_start              (op_start),
    .cvt_out_vld           (cvt_out_vld),
    .cvt_out_rdy           (cvt_out_rdy),
    .cvt_out_pd            (cvt_out_pd),
    .dp2reg_out_saturation (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] pd;
    int          ns;
    int          acc;
    bit          counted;
  } item_t;

  item_t       q[$];
  int          cyc;
  logic [31:0] mcnt;
  int          nvec;
  int          nerr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint rshift(input longint v, input int sh);
    longint r;
    r = v + ((sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1)));
    return r >>> sh;
  endfunction

  function automatic longint clampv(input longint v, input longint lo,
                                    input longint hi, inout int ns);
    if (v > hi) begin ns++; return hi; end
    if (v < lo) begin ns++; return lo; end
    return v;
  endfunction

  function automatic void ref_cvt(input logic [49:0] pd, input logic [1:0] ty,
                                  input logic [4:0] sh,
                                  output logic [17:0] o, output int ns);
    longint m, l;
    logic [8:0] m9, l9;
    ns = 0;
    if (ty == 2'd2) begin
      o = {pd[16], pd[16:0]};
    end else if (ty == 2'd0) begin
      m  = longint'($signed(pd[49:25]));
      l  = longint'($signed(pd[24:0]));
      m  = clampv(rshift(m, int'(sh)), -128, 127, ns);
      l  = clampv(rshift(l, int'(sh)), -128, 127, ns);
      m9 = 9'(m);
      l9 = 9'(l);
      o  = {m9, l9};
    end else begin
      l = longint'($signed(pd[32:0]));
      l = clampv(rshift(l, int'(sh)), -32768, 32767, ns);
      o = 18'(l);
    end
  endfunction

  function automatic bit exp_vld();
    return q.size() > 0 && (cyc - q[0].acc) >= 1;
  endfunction

  task automatic step(input logic v, input logic [49:0] pd,
                      input logic [1:0] ty, input logic [4:0] sh,
                      input logic ordy, input logic opst, output bit acc);
    bit cons;
    bit erdy;
    item_t it;
    longint s;
    mul_unit_vld = v;
    mul_unit_pd  = pd;
    dtype        = ty;
    shift        = sh;
    cvt_out_rdy  = ordy;
    op_start     = opst;
    #1;
    erdy = !(q.size() == 2 && !ordy);
    chk("vld", 64'(cvt_out_vld), 64'(exp_vld()));
    chk("rdy", 64'(mul_unit_rdy), 64'(erdy));
    chk("cnt", 64'(sat), 64'(mcnt));
    if (exp_vld())
      chk("pd", 64'(cvt_out_pd), 64'(q[0].pd));
    acc  = v && erdy;
    cons = exp_vld() && ordy;
    @(posedge clk);
    cyc++;
    if (cons) void'(q.pop_front());
    if (acc) begin
      ref_cvt(pd, ty, sh, it.pd, it.ns);
      it.acc     = cyc;
      it.counted = 1'b0;
      q.push_back(it);
    end
    if (exp_vld() && !q[0].counted) begin
      q[0].counted = 1'b1;
      s    = longint'(mcnt) + q[0].ns;
      mcnt = (s > 64'sh0FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    end
    if (opst) mcnt = '0;
    @(negedge clk);
  endtask

  task automatic send_chk(input logic [49:0] pd, input logic [1:0] ty,
                          input logic [4:0] sh, input logic [17:0] epd,
                          input logic [31:0] ecnt, input string nm);
    bit a;
    step(1'b1, pd, ty, sh, 1'b1, 1'b0, a);
    step(1'b0, '0, 2'd1, 5'd0, 1'b1, 1'b0, a);
    chk({nm, "_lit_pd"}, 64'(cvt_out_pd), 64'(epd));
    chk({nm, "_lit_cnt"}, 64'(sat), 64'(ecnt));
  endtask

  task automatic rand_in(output logic [49:0] pd, output logic [1:0] ty,
                         output logic [4:0] sh);
    logic [24:0] a, b;
    logic [32:0] w;
    ty = 2'($urandom_range(0, 3));
    sh = 5'($urandom);
    pd = {18'($urandom), $urandom};
    a  = 25'($urandom);
    b  = 25'($urandom);
    if ($urandom_range(0, 1) == 1) a = 25'($signed(12'($urandom)));
    if ($urandom_range(0, 1) == 1) b = 25'($signed(12'($urandom)));
    if (ty == 2'd0) pd = {a, b};
    w = {1'($urandom), $urandom};
    if ($urandom_range(0, 1) == 1) w = 33'($signed(20'($urandom)));
    if (ty[0]) pd[32:0] = w;
  endtask

  task automatic rand_steps(input int n);
    bit a;
    logic [49:0] pd;
    logic [1:0]  ty;
    logic [4:0]  sh;
    for (int i = 0; i < n; i++) begin
      rand_in(pd, ty, sh);
      step($urandom_range(0, 9) < 7, pd, ty, sh,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, a);
    end
  endtask

  initial begin
    bit a;
    int sent;
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    mcnt = '0;
    rstn = 1'b0;
    mul_unit_vld = 1'b0;
    mul_unit_pd  = '0;
    dtype        = 2'd0;
    shift        = 5'd0;
    op_start     = 1'b0;
    cvt_out_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 64'(cvt_out_vld), 64'd0);
    chk("rst_pd", 64'(cvt_out_pd), 64'd0);
    chk("rst_cnt", 64'(sat), 64'd0);
    chk("rst_rdy", 64'(mul_unit_rdy), 64'd1);
    rstn = 1'b1;

    send_chk(50'd1000, 2'd1, 5'd3, 18'h0007D, 32'd0, "r1000");
    send_chk(50'd1004, 2'd1, 5'd3, 18'd126, 32'd0, "r1004");
    send_chk(-50'sd5, 2'd1, 5'd1, 18'h3FFFE, 32'd0, "rneg5");
    send_chk({25'd300, 25'h0 - 25'd300}, 2'd0, 5'd0,
             {9'h07F, 9'h180}, 32'd2, "i8sat");
    send_chk(50'd40000, 2'd1, 5'd0, 18'h07FFF, 32'd3, "i16pos");
    send_chk(-50'sd40000, 2'd3, 5'd0, 18'h38000, 32'd4, "i16neg");
    send_chk(50'h13C00, 2'd2, 5'd7, 18'h33C00, 32'd4, "fp");

    sent = 0;
    for (int i = 0; i < 60 && sent < 8; i++) begin
      step(1'b1, 50'(sent * 1000 - 3500), 2'd1, 5'd2,
           (i % 4 == 0) || (i % 4 == 3), 1'b0, a);
      if (a) sent++;
    end
    if (sent < 8) begin
      nerr++;
      $display("FAIL bp_timeout: got %0d accepted expected 8", sent);
    end
    repeat (4) step(1'b0, '0, 2'd1, 5'd0, 1'b1, 1'b0, a);

    rand_steps(1500);

    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", 64'(cvt_out_vld), 64'd0);
    chk("arst_cnt", 64'(sat), 64'd0);
    chk("arst_rdy", 64'(mul_unit_rdy), 64'd1);
    q.delete();
    mcnt = '0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    rand_steps(300);
    repeat (4) step(1'b0, '0, 2'd1, 5'd0, 1'b1, 1'b0, a);

    force dut.sat_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.sat_cnt;
    mcnt = 32'hFFFF_FFFE;
    send_chk({25'd300, 25'h0 - 25'd300}, 2'd0, 5'd0,
             {9'h07F, 9'h180}, 32'hFFFF_FFFF, "stick");
    send_chk(50'd40000, 2'd1, 5'd0, 18'h07FFF, 32'hFFFF_FFFF, "stick2");

    step(1'b1, 50'd40000, 2'd1, 5'd0, 1'b1, 1'b0, a);
    step(1'b0, '0, 2'd1, 5'd0, 1'b1, 1'b1, a);
    chk("opst_pd", 64'(cvt_out_pd), 64'h07FFF);
    chk("opst_cnt", 64'(sat), 64'd0);
    repeat (3) step(1'b0, '0, 2'd1, 5'd0, 1'b1, 1'b0, a);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cdp_dp_mul_cvtout.md
# cdp_dp_mul_cvtout

Output converter for the CDP datapath, directly downstream of the CDP multiplier unit. It takes the 50-bit multiplier result (one int16 lane or two packed int8 lanes, or an fp17 passthrough). It right-shifts each integer lane with round-half-up, then saturates to the output precision. It emits an 18-bit packed output on a valid/ready pipe and keeps a running saturation count for the register file.

## Interface
Parameters: none (all widths fixed).

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset; asynchronous, active-low.
- mul_unit_vld  in  1  multiplier result valid.
- mul_unit_rdy  out  1  this block accepts the multiplier result.
- mul_unit_pd  in  50  multiplier result:
  - int8: msb lane [49:25], lsb lane [24:0], each a signed 25-bit value.
  - int16: signed value in [32:0].
  - fp16: fp17 in [16:0].
- reg2dp_input_data_type  in  2  0=int8, 1=int16, 2=fp16; 3 is treated as int16.
- reg2dp_datout_shifter  in  5  right-shift amount, 0..31.
- op_start  in  1  single-cycle pulse that clears the saturation counter.
- cvt_out_vld  out  1  output valid.
- cvt_out_rdy  in  1  downstream ready.
- cvt_out_pd  out  18  packed output:
  - int8: {msb lane 9b, lsb lane 9b}, each lane is an int8 sign-extended to 9 bits.
  - int16: {2 sign bits, int16}.
  - fp16: {pd[16], fp17}.
- dp2reg_out_saturation  out  32  count of saturated lanes since the last op_start.

## Operation
- Two-stage pipeline, S1 and S2.
  - S2 is the output register.
  - Each stage holds a valid bit, the data, and a 2-bit mode captured with the data.
  - Mode and shift are sampled at S1 load; config changes never affect data already in flight.
- S1 load:
  - Condition: mul_unit_vld & mul_unit_rdy.
  - Each integer lane is sign-extended to 34 bits.
  - The rounding constant is added: (shift==0 ? 0 : 1<<(shift-1)).
  - The 34-bit sums are stored with the shift amount and the mode.
- S2 load:
  - Each 34-bit sum is arithmetically shifted right by the stored shift.
  - The result is saturated:
    - int8: clamp to [-128, 127].
    - int16: clamp to [-32768, 32767].
  - Results are packed per the cvt_out_pd format.
- fp16 mode:
  - pd[16:0] passes through unchanged with the same 2-cycle latency.
  - There is no shift, round or saturation, and no count.
- Saturation counter:
  - On each S2 load it adds the number of lanes that clamped that cycle: 0 or 1 for int16, 0 to 2 for int8.
  - It sticks at 0xFFFFFFFF and does not wrap.
  - op_start clears it to 0. op_start has priority, and a same-cycle increment is discarded.
- Handshake, full-throughput pipe:
  - s2_rdy = ~s2_vld | cvt_out_rdy
  - s1_rdy = ~s1_vld | s2_rdy
  - mul_unit_rdy = s1_rdy (combinational)
- A stage holds its data while valid and not ready. Data and valid never change while cvt_out_vld & ~cvt_out_rdy.

## Timing
- Latency: exactly 2 cycles from an accepted input to cvt_out_vld, when there is no backpressure.
- Throughput: 1 result per cycle when cvt_out_rdy is held high.
- Reset values:
  - cvt_out_vld = 0, cvt_out_pd = 0, dp2reg_out_saturation = 0.
  - mul_unit_rdy = 1, because both stages are empty.
- Reset asserted mid-operation clears both valid bits immediately; in-flight data is dropped.
- Full pipe (2 entries) with cvt_out_rdy = 0: mul_unit_rdy = 0 in the same cycle.
- When cvt_out_rdy rises, both stages advance and a new input is accepted in that same cycle.
- Empty pipe: cvt_out_vld stays 0 and the counter is unchanged.
- dp2reg_out_saturation updates in the cycle after the S2 load, i.e. aligned with cvt_out_vld.

## Test plan
- int16 rounding:
  - pd[32:0] = 1000, shift = 3 → pd = 0x0007D (125), no saturation.
  - pd = 1004, shift = 3 → 126 (1004 + 4 = 1008, >>3).
  - pd = -5, shift = 1 → -2 (-5 + 1 = -4, >>1); pd = 0x3FFFE.
- int8 dual lane with saturation:
  - msb = 300, lsb = -300, shift = 0 → pd = {0x07F, 0x180}.
  - dp2reg_out_saturation increments by 2.
- int16 saturation:
  - pd = 40000, shift = 0 → 0x07FFF, count +1.
  - pd = -40000 → 0x38000, count +1.
- fp16 passthrough:
  - pd[16:0] = 0x13C00 with shift = 7 → pd = 0x33C00 after 2 cycles, count unchanged.
- Backpressure:
  - Stream 8 int16 inputs while cvt_out_rdy toggles 1,0,0,1,...
  - Check: outputs in order, none lost or duplicated.
  - Check: mul_unit_rdy is low exactly when both stages are full and cvt_out_rdy = 0.
  - Check: cvt_out_pd is stable while stalled.
- Counter edges:
  - Preload to 0xFFFFFFFE via saturating traffic (force), then saturate 2 lanes → 0xFFFFFFFF.
  - op_start coinciding with a saturating S2 load → 0.
  - Async reset mid-stream → cvt_out_vld = 0 and count = 0 immediately.
